// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter that sequences operations onto one shared combinational ALU.
// One operation in flight: IDLE grants, EXEC holds the ALU inputs, RESP returns the captured result.
module alu_arbiter #(
  parameter int   EXEC_CYCLES = 1,
  parameter logic PRIO_RESET  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  // Handshake (request and response alike): a transfer happens at a rising edge where
  // valid and ready are both high; until then the presenter keeps valid and its fields stable.
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [31:0] req_x_0,
  input  logic [31:0] req_y_0,
  input  logic        req_add_sub_0,
  input  logic        req_constvar_0,
  input  logic [1:0]  req_logicfn_0,
  input  logic [1:0]  req_shiftfn_0,
  input  logic [2:0]  req_fnclass_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [31:0] req_x_1,
  input  logic [31:0] req_y_1,
  input  logic        req_add_sub_1,
  input  logic        req_constvar_1,
  input  logic [1:0]  req_logicfn_1,
  input  logic [1:0]  req_shiftfn_1,
  input  logic [2:0]  req_fnclass_1,
  output logic        resp_valid_0,
  input  logic        resp_ready_0,
  output logic [31:0] resp_result_0,
  output logic        resp_overflow_0,
  output logic        resp_valid_1,
  input  logic        resp_ready_1,
  output logic [31:0] resp_result_1,
  output logic        resp_overflow_1,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic        alu_add_sub,
  output logic        alu_constvar,
  output logic [1:0]  alu_logicfn,
  output logic [1:0]  alu_shiftfn,
  output logic [2:0]  alu_fnclass,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0] state;
  logic       prio;
  logic       owner;
  logic [2:0] cnt;
  logic       grant;
  logic       accept;
  logic       exec_done;
  logic       resp_ack;

  // The priority holder wins when valid; otherwise the other requester if it is valid.
  always_comb begin
    grant = prio;
    if (prio ? req_valid_1 : req_valid_0) grant = prio;
    else if (prio ? req_valid_0 : req_valid_1) grant = ~prio;
  end

  assign req_ready_0  = (state == ST_IDLE) && !grant;
  assign req_ready_1  = (state == ST_IDLE) && grant;
  assign accept       = (req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1);
  assign exec_done    = (cnt == 3'(EXEC_CYCLES - 1));
  assign resp_valid_0 = (state == ST_RESP) && !owner;
  assign resp_valid_1 = (state == ST_RESP) && owner;
  assign resp_ack     = owner ? resp_ready_1 : resp_ready_0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      prio            <= PRIO_RESET;
      owner           <= 1'b0;
      cnt             <= 3'd0;
      resp_result_0   <= 32'd0;
      resp_overflow_0 <= 1'b0;
      resp_result_1   <= 32'd0;
      resp_overflow_1 <= 1'b0;
      alu_x           <= 32'd0;
      alu_y           <= 32'd0;
      alu_add_sub     <= 1'b0;
      alu_constvar    <= 1'b0;
      alu_logicfn     <= 2'd0;
      alu_shiftfn     <= 2'd0;
      alu_fnclass     <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_x        <= grant ? req_x_1        : req_x_0;
            alu_y        <= grant ? req_y_1        : req_y_0;
            alu_add_sub  <= grant ? req_add_sub_1  : req_add_sub_0;
            alu_constvar <= grant ? req_constvar_1 : req_constvar_0;
            alu_logicfn  <= grant ? req_logicfn_1  : req_logicfn_0;
            alu_shiftfn  <= grant ? req_shiftfn_1  : req_shiftfn_0;
            alu_fnclass  <= grant ? req_fnclass_1  : req_fnclass_0;
            owner        <= grant;
            prio         <= ~grant;
            cnt          <= 3'd0;
            state        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt <= cnt + 3'd1;
          if (exec_done) begin
            if (owner) begin
              resp_result_1   <= alu_result;
              resp_overflow_1 <= alu_overflow;
            end else begin
              resp_result_0   <= alu_result;
              resp_overflow_0 <= alu_overflow;
            end
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ack) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (EXEC_CYCLES=1/PRIO_RESET=0 and EXEC_CYCLES=3/PRIO_RESET=1)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_alu_arbiter;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        add_sub;
    logic        constvar;
    logic [1:0]  logicfn;
    logic [1:0]  shiftfn;
    logic [2:0]  fnclass;
  } op_t;

  typedef struct {
    int k;
    int who;
    int cyc;
  } acc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req_valid [2][2];
  op_t         req_op [2][2];
  logic        resp_ready [2][2];
  wire         req_ready [2][2];
  wire         resp_valid [2][2];
  wire  [31:0] resp_result [2][2];
  wire         resp_overflow [2][2];
  wire  [31:0] alu_x [2];
  wire  [31:0] alu_y [2];
  wire         alu_add_sub [2];
  wire         alu_constvar [2];
  wire  [1:0]  alu_logicfn [2];
  wire  [1:0]  alu_shiftfn [2];
  wire  [2:0]  alu_fnclass [2];
  op_t         dut_op [2];
  logic [31:0] alu_result [2];
  logic        alu_overflow [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference ALU: drives the DUT's ALU inputs and also predicts every response.
  function automatic logic [32:0] alu_ref(input op_t o);
    logic [31:0] r;
    logic        v;
    logic [4:0]  amt;
    r = '0;
    v = 1'b0;
    amt = o.constvar ? o.y[4:0] : 5'd1;
    case (o.fnclass)
      3'd0: begin
        if (!o.add_sub) begin
          r = o.x + o.y;
          v = (o.x[31] == o.y[31]) && (r[31] != o.x[31]);
        end else begin
          r = o.x - o.y;
          v = (o.x[31] != o.y[31]) && (r[31] != o.x[31]);
        end
      end
      3'd1: begin
        case (o.logicfn)
          2'd0:    r = o.x & o.y;
          2'd1:    r = o.x | o.y;
          2'd2:    r = o.x ^ o.y;
          default: r = ~(o.x | o.y);
        endcase
      end
      3'd2: begin
        case (o.shiftfn)
          2'd0:    r = o.x << amt;
          2'd1:    r = o.x >> amt;
          2'd2:    r = $signed(o.x) >>> amt;
          default: r = (o.x << amt) | (o.x >> (6'd32 - {1'b0, amt}));
        endcase
      end
      3'd3:    r = {31'd0, $signed(o.x) < $signed(o.y)};
      default: r = '0;
    endcase
    return {v, r};
  endfunction

  function automatic int ec(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic prio_rst(input int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    alu_arbiter #(
      .EXEC_CYCLES((k == 0) ? 1 : 3),
      .PRIO_RESET ((k == 0) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk             (clk),
      .rst             (rst[k]),
      .req_valid_0     (req_valid[k][0]),
      .req_ready_0     (req_ready[k][0]),
      .req_x_0         (req_op[k][0].x),
      .req_y_0         (req_op[k][0].y),
      .req_add_sub_0   (req_op[k][0].add_sub),
      .req_constvar_0  (req_op[k][0].constvar),
      .req_logicfn_0   (req_op[k][0].logicfn),
      .req_shiftfn_0   (req_op[k][0].shiftfn),
      .req_fnclass_0   (req_op[k][0].fnclass),
      .req_valid_1     (req_valid[k][1]),
      .req_ready_1     (req_ready[k][1]),
      .req_x_1         (req_op[k][1].x),
      .req_y_1         (req_op[k][1].y),
      .req_add_sub_1   (req_op[k][1].add_sub),
      .req_constvar_1  (req_op[k][1].constvar),
      .req_logicfn_1   (req_op[k][1].logicfn),
      .req_shiftfn_1   (req_op[k][1].shiftfn),
      .req_fnclass_1   (req_op[k][1].fnclass),
      .resp_valid_0    (resp_valid[k][0]),
      .resp_ready_0    (resp_ready[k][0]),
      .resp_result_0   (resp_result[k][0]),
      .resp_overflow_0 (resp_overflow[k][0]),
      .resp_valid_1    (resp_valid[k][1]),
      .resp_ready_1    (resp_ready[k][1]),
      .resp_result_1   (resp_result[k][1]),
      .resp_overflow_1 (resp_overflow[k][1]),
      .alu_x           (alu_x[k]),
      .alu_y           (alu_y[k]),
      .alu_add_sub     (alu_add_sub[k]),
      .alu_constvar    (alu_constvar[k]),
      .alu_logicfn     (alu_logicfn[k]),
      .alu_shiftfn     (alu_shiftfn[k]),
      .alu_fnclass     (alu_fnclass[k]),
      .alu_result      (alu_result[k]),
      .alu_overflow    (alu_overflow[k])
    );
    assign dut_op[k] = {alu_x[k], alu_y[k], alu_add_sub[k], alu_constvar[k],
                        alu_logicfn[k], alu_shiftfn[k], alu_fnclass[k]};
    assign {alu_overflow[k], alu_result[k]} = alu_ref(dut_op[k]);
  end

  task automatic chk(input string name, input int k, input int r,
                     input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL i%0d.%s_%0d actual=%0h expected=%0h (cycle %0d)", k, name, r, act, exp, cyc);
    end
  endtask

  // Transaction model: op in flight, its age in cycles since accept, and last delivered results.
  logic        m_on [2];
  logic        m_busy [2];
  logic        m_owner [2];
  logic        m_prio [2];
  int          m_age [2];
  op_t         m_op [2];
  logic [31:0] m_res [2][2];
  logic        m_ovf [2][2];
  acc_t        acc_q[$];

  function automatic int grant_of(input int k);
    logic p;
    p = m_prio[k];
    if (req_valid[k][p]) return int'(p);
    if (req_valid[k][!p]) return int'(!p);
    return int'(p);
  endfunction

  task automatic check_inst(input int k);
    for (int r = 0; r < 2; r++) begin
      chk("req_ready", k, r, req_ready[k][r], !m_busy[k] && (grant_of(k) == r));
      chk("resp_valid", k, r, resp_valid[k][r],
          m_busy[k] && (m_age[k] > ec(k)) && (int'(m_owner[k]) == r));
      chk("resp_result", k, r, resp_result[k][r], m_res[k][r]);
      chk("resp_overflow", k, r, resp_overflow[k][r], m_ovf[k][r]);
    end
    chk("alu_inputs", k, 0, dut_op[k], m_op[k]);
  endtask

  task automatic step_model(input int k);
    int   g;
    acc_t a;
    if (rst[k]) begin
      m_on[k] = 1'b1;
      m_busy[k] = 1'b0;
      m_owner[k] = 1'b0;
      m_prio[k] = prio_rst(k);
      m_age[k] = 0;
      m_op[k] = '0;
      for (int r = 0; r < 2; r++) begin
        m_res[k][r] = '0;
        m_ovf[k][r] = 1'b0;
      end
    end else if (!m_on[k]) begin
      return;
    end else if (!m_busy[k]) begin
      g = grant_of(k);
      if (req_valid[k][g]) begin
        m_busy[k] = 1'b1;
        m_owner[k] = g[0];
        m_prio[k] = !g[0];
        m_age[k] = 1;
        m_op[k] = req_op[k][g];
        a.k = k;
        a.who = g;
        a.cyc = cyc;
        acc_q.push_back(a);
      end
    end else if (m_age[k] <= ec(k)) begin
      m_age[k]++;
      if (m_age[k] == ec(k) + 1)
        {m_ovf[k][m_owner[k]], m_res[k][m_owner[k]]} = alu_ref(m_op[k]);
    end else if (resp_ready[k][m_owner[k]]) begin
      m_busy[k] = 1'b0;
    end
  endtask

  // Compare process: outputs are stable at the falling edge; inputs seen here are the ones the next edge samples.
  initial begin
    m_on[0] = 1'b0;
    m_on[1] = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (m_on[k]) check_inst(k);
        step_model(k);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic op_t mk(input logic [31:0] x, input logic [31:0] y, input logic [2:0] cls,
                             input logic as, input logic cv, input logic [1:0] lf, input logic [1:0] sf);
    op_t o;
    o.x = x;
    o.y = y;
    o.fnclass = cls;
    o.add_sub = as;
    o.constvar = cv;
    o.logicfn = lf;
    o.shiftfn = sf;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.x = $urandom;
    o.y = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom;
    o.fnclass = 3'($urandom_range(0, 4));
    o.add_sub = 1'($urandom_range(0, 1));
    o.constvar = 1'($urandom_range(0, 1));
    o.logicfn = 2'($urandom_range(0, 3));
    o.shiftfn = 2'($urandom_range(0, 3));
    return o;
  endfunction

  // Presents an op and returns one cycle after the accept edge, then idles for gap cycles.
  task automatic issue(input int k, input int r, input op_t o, input int gap);
    logic got;
    req_op[k][r] = o;
    req_valid[k][r] = 1'b1;
    for (int n = 0; ; n++) begin
      if (n == 200) begin
        chk("accept_timeout", k, r, 1'b0, 1'b1);
        req_valid[k][r] = 1'b0;
        return;
      end
      @(negedge clk);
      got = req_ready[k][r];
      tick();
      if (got) break;
    end
    req_valid[k][r] = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic stream(input int k, input int r, input int n, input int max_gap);
    for (int i = 0; i < n; i++) issue(k, r, rand_op(), $urandom_range(0, max_gap));
  endtask

  task automatic wait_resp(input int k, input int r);
    for (int n = 0; n < 50 && resp_valid[k][r] !== 1'b1; n++) tick();
    chk("resp_wait", k, r, resp_valid[k][r], 1'b1);
  endtask

  task automatic check_order(input int k, input int from, input int n, input int first, input int gap);
    int seen;
    int prev;
    int want;
    seen = 0;
    prev = -1;
    want = first;
    for (int i = from; i < acc_q.size(); i++) begin
      if (acc_q[i].k != k) continue;
      chk("grant_order", k, seen, acc_q[i].who, want);
      if (prev >= 0) chk("issue_interval", k, seen, acc_q[i].cyc - prev, gap);
      prev = acc_q[i].cyc;
      want = 1 - want;
      seen++;
    end
    chk("accept_count", k, 0, seen, n);
  endtask

  logic        soak_done;
  logic [31:0] held_res;
  logic        held_ovf;
  int          idx;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      for (int r = 0; r < 2; r++) begin
        req_valid[k][r] = 1'b0;
        req_op[k][r] = '0;
        resp_ready[k][r] = 1'b1;
      end
    end
    soak_done = 1'b0;

    chk("ref_add", 0, 0, alu_ref(mk(32'd5, 32'd3, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0)), 33'h0_0000_0008);
    chk("ref_ovf", 0, 0, alu_ref(mk(32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0)), 33'h1_8000_0000);
    chk("ref_sub", 0, 0, alu_ref(mk(32'd3, 32'd5, 3'd0, 1'b1, 1'b0, 2'd0, 2'd0)), 33'h0_FFFF_FFFE);
    chk("ref_shl", 0, 0, alu_ref(mk(32'd1, 32'd4, 3'd2, 1'b0, 1'b1, 2'd0, 2'd0)), 33'h0_0000_0010);

    // Instance 0: EXEC_CYCLES = 1, PRIO_RESET = 0.
    repeat (2) tick();
    rst[0] = 1'b0;
    settle();
    chk("reset_ready", 0, 0, req_ready[0][0], 1'b1);
    chk("reset_alu_x", 0, 0, alu_x[0], 32'd0);

    issue(0, 0, mk(32'd5, 32'd3, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0), 0);
    chk("lat_exec_valid", 0, 0, resp_valid[0][0], 1'b0);
    tick();
    chk("add_valid", 0, 0, resp_valid[0][0], 1'b1);
    chk("add_result", 0, 0, resp_result[0][0], 32'd8);
    chk("add_overflow", 0, 0, resp_overflow[0][0], 1'b0);
    chk("other_valid", 0, 1, resp_valid[0][1], 1'b0);

    issue(0, 1, mk(32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0), 0);
    tick();
    chk("ovf_result", 0, 1, resp_result[0][1], 32'h8000_0000);
    chk("ovf_overflow", 0, 1, resp_overflow[0][1], 1'b1);
    issue(0, 1, mk(32'd3, 32'd5, 3'd0, 1'b1, 1'b0, 2'd0, 2'd0), 0);
    tick();
    chk("sub_result", 0, 1, resp_result[0][1], 32'hFFFF_FFFE);

    idx = acc_q.size();
    fork
      stream(0, 0, 4, 0);
      stream(0, 1, 4, 0);
    join
    check_order(0, idx, 8, 0, 3);

    // Stalled response: owner 1 holds off for 5 cycles while both requesters wait.
    repeat (3) tick();
    resp_ready[0][1] = 1'b0;
    issue(0, 1, rand_op(), 0);
    wait_resp(0, 1);
    held_res = resp_result[0][1];
    held_ovf = resp_overflow[0][1];
    req_op[0][0] = rand_op();
    req_op[0][1] = rand_op();
    req_valid[0][0] = 1'b1;
    req_valid[0][1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_valid", 0, i, resp_valid[0][1], 1'b1);
      chk("stall_result", 0, i, resp_result[0][1], held_res);
      chk("stall_overflow", 0, i, resp_overflow[0][1], held_ovf);
      chk("stall_ready", 0, i, {req_ready[0][0], req_ready[0][1]}, 2'b00);
      tick();
    end
    resp_ready[0][1] = 1'b1;
    tick();
    settle();
    chk("release_grant", 0, 0, {req_ready[0][0], req_ready[0][1]}, 2'b10);
    tick();
    req_valid[0][0] = 1'b0;
    req_valid[0][1] = 1'b0;
    repeat (4) tick();

    // Instance 1: EXEC_CYCLES = 3, PRIO_RESET = 1.
    rst[1] = 1'b0;
    settle();
    chk("reset_ready", 1, 1, {req_ready[1][0], req_ready[1][1]}, 2'b01);
    issue(1, 0, mk(32'd1, 32'd4, 3'd2, 1'b0, 1'b1, 2'd0, 2'd0), 0);
    for (int i = 1; i <= 3; i++) begin
      chk("exec_alu_x", 1, i, alu_x[1], 32'd1);
      chk("exec_alu_y", 1, i, alu_y[1], 32'd4);
      chk("exec_no_valid", 1, i, resp_valid[1][0], 1'b0);
      tick();
    end
    chk("shift_valid", 1, 0, resp_valid[1][0], 1'b1);
    chk("shift_result", 1, 0, resp_result[1][0], 32'h10);
    tick();

    issue(1, 0, rand_op(), 0);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    chk("abort_valid", 1, 0, {resp_valid[1][0], resp_valid[1][1]}, 2'b00);
    chk("abort_alu", 1, 0, dut_op[1], 73'd0);
    resp_ready[1][1] = 1'b0;
    issue(1, 1, rand_op(), 0);
    wait_resp(1, 1);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    resp_ready[1][1] = 1'b1;
    chk("abort_resp_valid", 1, 1, resp_valid[1][1], 1'b0);
    idx = acc_q.size();
    fork
      stream(1, 0, 2, 0);
      stream(1, 1, 2, 0);
    join
    check_order(1, idx, 4, 1, 5);
    repeat (6) tick();

    // Random soak on both instances with random gaps and response back-pressure.
    fork
      begin
        fork
          stream(0, 0, 8, 3);
          stream(0, 1, 8, 3);
          stream(1, 0, 8, 3);
          stream(1, 1, 8, 3);
        join
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          tick();
          for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++)
              resp_ready[k][r] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 2; r++)
        resp_ready[k][r] = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares the single combinational 32-bit ALU between two independent issuers, for example the main execute stage and an address/branch helper. It accepts one operation at a time through valid/ready handshakes and uses round-robin priority. It registers the operands and function controls, holds them stable on the ALU inputs for a programmable number of cycles, and captures result and overflow. It then returns them to the issuing requester on a held valid/ready response channel.

## Interface
Parameters:
- EXEC_CYCLES, 1, cycles the ALU inputs are held before capture (legal 1..4)
- PRIO_RESET, 0, requester with priority after reset

Ports (r = 0, 1; every per-requester port exists once per requester):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_r  in  1  requester r presents an operation
- req_ready_r  out  1  arbiter accepts requester r this cycle
- req_x_r, req_y_r  in  32  operands
- req_add_sub_r  in  1  ALU add/subtract select
- req_constvar_r  in  1  ALU shift-amount source select
- req_logicfn_r  in  2  ALU logic function
- req_shiftfn_r  in  2  ALU shift function
- req_fnclass_r  in  3  ALU result class
- resp_valid_r  out  1  result for requester r available
- resp_ready_r  in  1  requester r consumes result
- resp_result_r  out  32  captured ALU result
- resp_overflow_r  out  1  captured ALU overflow
- alu_x, alu_y  out  32  registered operands to the ALU
- alu_add_sub, alu_constvar  out  1  registered controls
- alu_logicfn, alu_shiftfn  out  2  registered controls
- alu_fnclass  out  3  registered control
- alu_result  in  32  combinational ALU result
- alu_overflow  in  1  combinational ALU overflow

## Operation
- The block has three states: IDLE, EXEC and RESP, with one operation in flight at most.
- IDLE: grant = prio if req_valid_prio, else the other requester if it is valid. req_ready_grant = 1; the other req_ready = 0.
- In RESP and EXEC, both req_ready are 0.
- An accept is req_valid_r & req_ready_r at an edge. On accept:
  - latch all request fields into the alu_* registers;
  - owner <= r;
  - prio <= ~r;
  - exec counter <= 0;
  - go to EXEC.
- prio changes only on accept. With one requester active, that requester is served back-to-back.
- EXEC: the alu_* registers are constant. The counter increments each cycle. At the edge ending the EXEC_CYCLES-th EXEC cycle:
  - resp_result_owner <= alu_result;
  - resp_overflow_owner <= alu_overflow;
  - go to RESP.
- RESP: resp_valid_owner = 1 and the non-owner resp_valid = 0. resp_result and resp_overflow hold until resp_ready_owner = 1 at an edge; then go to IDLE. The non-owner's resp_ready is ignored.
- The arbiter performs no arithmetic; the ALU is the only function source, and result width is 32 bits, taken unmodified.
- Reset values:
  - state = IDLE, prio = PRIO_RESET, owner = 0, counter = 0;
  - all resp_valid_r = 0, resp_result_r = 0, resp_overflow_r = 0;
  - all alu_* outputs = 0.
- req_ready_r in the first post-reset cycle follows the IDLE rule.
- Reset mid-operation (EXEC or RESP) discards the operation: no response is ever emitted for it, and prio returns to PRIO_RESET.
- A requester must keep its request fields stable while req_valid_r is high and req_ready_r is low.

## Timing
- Accept at edge N. EXEC occupies cycles N+1 through N+EXEC_CYCLES. resp_valid rises in cycle N+EXEC_CYCLES+1.
- Latency from accept to resp_valid is EXEC_CYCLES+1 cycles; for EXEC_CYCLES = 1 that is 2.
- Response consumed at edge M: IDLE in cycle M+1, and the next accept is possible at edge M+1.
- Minimum issue interval is EXEC_CYCLES+2 cycles.
- When both requesters hold valid continuously, grants alternate strictly.
- The alu_* outputs change only at accept edges; they hold their last values in IDLE and RESP.
- req_ready depends combinationally on req_valid (grant select) and on registered state only. There is no combinational path from alu_result to any req_ready.

## Test plan
- Requester 0, arithmetic class, add_sub = 0, x = 5, y = 3, EXEC_CYCLES = 1 -> resp_valid_0 two cycles after accept, result 8, overflow 0; resp_valid_1 stays 0.
- Requester 1 adds x = 0x7FFFFFFF, y = 1 -> resp_result_1 = 0x80000000, resp_overflow_1 = 1. Subtract x = 3, y = 5 -> 0xFFFFFFFE.
- Both requesters always valid, resp_ready tied high, 4 ops each, PRIO_RESET = 0 -> grant order 0,1,0,1,0,1,0,1; one accept every 3 cycles; every response goes to its issuer and matches the ALU reference model.
- resp_ready_1 held low 5 cycles during RESP -> resp_valid_1 stays high; result and overflow are stable; both req_ready are 0; the accept after release goes to requester 0.
- rst asserted in the EXEC cycle of a requester 0 op, PRIO_RESET = 1 -> next cycle all resp_valid = 0 and alu_* = 0; no response for the aborted op; with both requesters valid, requester 1 is granted first.
- EXEC_CYCLES = 3 -> alu_* constant for 3 EXEC cycles, resp_valid 4 cycles after accept; a shift-class op x = 0x1, y = 4 returns the ALU model's value.
